// File: rtl/macro_board_evaluator.sv
// macro_board_evaluator
// Scans the nine used macro cells out of the board-state RAM and decides the
// overall game outcome: ongoing, player 1 win, player 2 win or draw. Also
// flags a board on which both players own a complete line.
//
// Handshake: start is a request that is only looked at while idle (busy=0);
// requests seen while busy are dropped, not queued. done is a one-cycle
// pulse in the last busy cycle. result/win_line/conflict are valid from
// that cycle on and hold until the next evaluation or reset.
module macro_board_evaluator #(
    parameter logic [3:0] ADDR_BASE = 4'd1,
    parameter logic [3:0] IDLE_ADDR = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [3:0] mem_addr,
    input  logic [1:0] mem_q,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [2:0] win_line,
    output logic       conflict,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;

    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [1:0] r_cell [1:9];
    logic [1:0] r_result;
    logic [2:0] r_win_line;
    logic       r_conflict;

    logic [5:0] w_line [8];
    logic [7:0] w_p1_own;
    logic [7:0] w_p2_own;
    logic [2:0] w_p1_line;
    logic [2:0] w_p2_line;
    logic       w_full;
    logic [1:0] w_result;
    logic [2:0] w_win_line;
    logic       w_conflict;

    // Three cells of each line, indexed by line number.
    assign w_line[0] = {r_cell[1], r_cell[2], r_cell[3]};
    assign w_line[1] = {r_cell[4], r_cell[5], r_cell[6]};
    assign w_line[2] = {r_cell[7], r_cell[8], r_cell[9]};
    assign w_line[3] = {r_cell[1], r_cell[4], r_cell[7]};
    assign w_line[4] = {r_cell[2], r_cell[5], r_cell[8]};
    assign w_line[5] = {r_cell[3], r_cell[6], r_cell[9]};
    assign w_line[6] = {r_cell[1], r_cell[5], r_cell[9]};
    assign w_line[7] = {r_cell[3], r_cell[5], r_cell[7]};

    // Address is only non-idle while a cell read is actually being issued (idx 1..9).
    assign mem_addr  = (r_state == S_READ && r_idx <= 4'd9) ? (ADDR_BASE + r_idx - 4'd1) : IDLE_ADDR;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign win_line  = r_win_line;
    assign conflict  = r_conflict;
    assign dbg_state = r_state;

    // Line ownership, lowest owned line per player, board-full detection and outcome priority.
    always_comb begin
        w_p1_own  = 8'd0;
        w_p2_own  = 8'd0;
        w_p1_line = 3'd0;
        w_p2_line = 3'd0;
        w_full    = 1'b1;
        for (int l = 0; l < 8; l++) begin
            w_p1_own[l] = (w_line[l] == {P1, P1, P1});
            w_p2_own[l] = (w_line[l] == {P2, P2, P2});
        end
        for (int l = 7; l >= 0; l--) begin
            if (w_p1_own[l]) w_p1_line = 3'(l);
            if (w_p2_own[l]) w_p2_line = 3'(l);
        end
        for (int k = 1; k <= 9; k++) begin
            if (r_cell[k] == 2'b00) w_full = 1'b0;
        end
        w_conflict = (|w_p1_own) && (|w_p2_own);
        if (|w_p1_own) begin
            w_result   = P1;
            w_win_line = w_p1_line;
        end else if (|w_p2_own) begin
            w_result   = P2;
            w_win_line = w_p2_line;
        end else if (w_full) begin
            w_result   = 2'b11;
            w_win_line = 3'd0;
        end else begin
            w_result   = 2'b00;
            w_win_line = 3'd0;
        end
    end

    // Scan sequencer: read data lags the address by one cycle, so cell idx-1 is captured while idx is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            for (int k = 1; k <= 9; k++) r_cell[k] <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_idx   <= 4'd1;
                    end
                end
                S_READ: begin
                    for (int k = 1; k <= 9; k++) begin
                        if (r_idx == 4'(k + 1)) r_cell[k] <= mem_q;
                    end
                    if (r_idx == 4'd10) begin
                        r_state <= S_EVAL;
                        r_idx   <= 4'd0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_EVAL:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outcome registers load once per scan, at the end of EVAL, and hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result   <= 2'b00;
            r_win_line <= 3'd0;
            r_conflict <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_result   <= w_result;
            r_win_line <= w_win_line;
            r_conflict <= w_conflict;
        end
    end

endmodule

// File: tb/tb_macro_board_evaluator.sv
// Testbench for macro_board_evaluator: a registered-address RAM model feeds
// the scan, expected outcomes and done cycles are queued when a scan starts
// and checked when done pulses.
module tb_macro_board_evaluator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mem_addr;
    logic [1:0] mem_q;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [2:0] win_line;
    logic       conflict;
    logic [1:0] dbg_state;

    logic [1:0] ram [0:9];
    logic [3:0] ram_addr_q = 4'd0;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_done = 0;

    logic [5:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [5:0] mon_e;
    int         mon_ec;

    macro_board_evaluator dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .win_line  (win_line),
        .conflict  (conflict),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter / RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_addr_q <= mem_addr;
    assign mem_q = (ram_addr_q <= 4'd9) ? ram[ram_addr_q] : 2'b00;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: cell k lives in b[2k-1:2k-2]; returns {result, win_line, conflict}.
    function automatic logic [5:0] eval_model(input logic [17:0] b);
        int         ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                                  '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        logic [1:0] c [10];
        bit         p1, p2, full;
        logic [2:0] w1, w2;
        logic [1:0] res;
        logic [2:0] wl;
        c[0] = 2'b00;
        for (int k = 1; k <= 9; k++) c[k] = b[2*k-2 +: 2];
        p1 = 0; p2 = 0; w1 = 0; w2 = 0; full = 1;
        for (int l = 0; l < 8; l++) begin
            if (c[ln[l][0]] == 2'b01 && c[ln[l][1]] == 2'b01 && c[ln[l][2]] == 2'b01) begin
                if (!p1) w1 = 3'(l);
                p1 = 1;
            end
            if (c[ln[l][0]] == 2'b10 && c[ln[l][1]] == 2'b10 && c[ln[l][2]] == 2'b10) begin
                if (!p2) w2 = 3'(l);
                p2 = 1;
            end
        end
        for (int k = 1; k <= 9; k++) if (c[k] == 2'b00) full = 0;
        if (p1)        begin res = 2'b01; wl = w1; end
        else if (p2)   begin res = 2'b10; wl = w2; end
        else if (full) begin res = 2'b11; wl = 3'd0; end
        else           begin res = 2'b00; wl = 3'd0; end
        return {res, wl, p1 & p2};
    endfunction

    task automatic load_board(input logic [17:0] b);
        ram[0] = 2'b11;
        for (int k = 1; k <= 9; k++) ram[k] = b[2*k-2 +: 2];
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued scan.
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_miss++;
                $error("FAIL unexpected_done: observed done at cycle %0d expected no done", cyc);
            end
            if (exp_q.size() != 0) begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                check("result",     32'(result),   32'(mon_e[5:4]));
                check("win_line",   32'(win_line), 32'(mon_e[3:1]));
                check("conflict",   32'(conflict), 32'(mon_e[0]));
                check("done_cycle", 32'(cyc),      32'(mon_ec));
            end
        end
    end

    // Driver: one scan; optional address trace, stray starts while busy, RAM writes mid-scan.
    task automatic run_scan(input logic [17:0] b, input logic [5:0] exp,
                            input bit trace, input bit extra_starts, input bit mid_write);
        @(negedge clk);
        load_board(b);
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 12);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("busy_in_scan", 32'(busy), 32'd1);
            if (trace && k <= 10)
                check("addr_trace", 32'(mem_addr), (k <= 9) ? 32'(k) : 32'd0);
            if (extra_starts) start = (k == 3 || k == 7);
            if (mid_write && k == 6) begin
                ram[1] = 2'b00;
                ram[7] = 2'b10;
                ram[8] = 2'b10;
                ram[9] = 2'b10;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_after_scan", 32'(busy), 32'd0);
        check("addr_idle", 32'(mem_addr), 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int c0;
        logic [17:0] rb;
        load_board(18'd0);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_result",   32'(result),    32'd0);
        check("rst_win_line", 32'(win_line),  32'd0);
        check("rst_conflict", 32'(conflict),  32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_state",    32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // cells 2=01, 5=10, 7=11: ongoing, with full address trace
        run_scan({2'b00,2'b00,2'b11,2'b00,2'b10,2'b00,2'b00,2'b01,2'b00}, 6'b00_000_0, 1, 0, 0);
        // cells 3,5,7 = P2: diagonal line 7
        run_scan({2'b00,2'b00,2'b10,2'b00,2'b10,2'b00,2'b10,2'b00,2'b00}, 6'b10_111_0, 0, 0, 0);
        // P1 row 0 and P2 row 2: conflict, P1 reported
        run_scan({2'b10,2'b10,2'b10,2'b00,2'b00,2'b00,2'b01,2'b01,2'b01}, 6'b01_000_1, 0, 0, 0);
        // full board, no owned line: draw
        run_scan({2'b11,2'b01,2'b10,2'b10,2'b10,2'b01,2'b01,2'b10,2'b01}, 6'b11_000_0, 0, 0, 0);
        // P1 owns columns 4 and 5: lowest index reported
        run_scan({2'b01,2'b01,2'b00,2'b01,2'b01,2'b00,2'b01,2'b01,2'b00}, 6'b01_100_0, 0, 0, 0);
        // RAM written mid-scan: cell 1 already sampled, cells 7..9 not yet
        run_scan({2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,2'b01}, 6'b01_000_1, 0, 0, 1);
        // random boards against the model
        for (int r = 0; r < 4; r++) begin
            rb = 18'($urandom_range(0, 262143));
            run_scan(rb, eval_model(rb), 0, 0, 0);
        end
        wait_drain();

        // start pulses while busy are ignored
        d0 = n_done;
        run_scan({2'b00,2'b00,2'b10,2'b00,2'b10,2'b00,2'b10,2'b00,2'b00}, 6'b10_111_0, 0, 1, 0);
        repeat (20) @(negedge clk);
        check("one_done_per_request", 32'(n_done - d0), 32'd1);

        // start held: a new scan every 13 cycles
        @(negedge clk);
        d0 = n_done;
        c0 = cyc;
        load_board({2'b10,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00});
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(6'b10_010_0);
            exp_cyc_q.push_back(c0 + 12 + 13 * s);
        end
        start = 1'b1;
        repeat (38) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (15) @(negedge clk);
        check("held_start_dones", 32'(n_done - d0), 32'd3);

        // async reset at idx=5 abandons the scan
        d0 = n_done;
        load_board({2'b11,2'b01,2'b10,2'b10,2'b10,2'b01,2'b01,2'b10,2'b01});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_addr", 32'(mem_addr), 32'd5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",   32'(busy),     32'd0);
        check("mid_rst_addr",   32'(mem_addr), 32'd0);
        @(negedge clk);
        check("post_rst_busy",     32'(busy),     32'd0);
        check("post_rst_done",     32'(done),     32'd0);
        check("post_rst_result",   32'(result),   32'd0);
        check("post_rst_win_line", 32'(win_line), 32'd0);
        check("post_rst_addr",     32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 32'(n_done - d0), 32'd0);

        // fresh scan after reset completes normally
        run_scan({2'b11,2'b01,2'b10,2'b10,2'b10,2'b01,2'b01,2'b10,2'b01}, 6'b11_000_0, 1, 0, 0);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
